// File: rtl/qfold_pkg.sv
// qfold_pkg: shared constants and stage tag for quadrant_fold_pipe (QFOLD_OCTANT_EN adds oct_swap)
package qfold_pkg;
  localparam int QF_WIDTH = 16;
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;
  typedef struct packed {
    logic [1:0] quad;
    logic sat;
`ifdef QFOLD_OCTANT_EN
    logic oct_swap;
`endif
  } qfold_tag_t;
endpackage

// File: rtl/quadrant_fold_pipe_if.sv
// quadrant_fold_pipe_if: handshake and data bundle of quadrant_fold_pipe (QFOLD_OCTANT_EN adds oct_swap)
interface quadrant_fold_pipe_if import qfold_pkg::*; #(
  parameter int WIDTH = QF_WIDTH,
  parameter int CNT_W = 16
);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic mode;
  logic [2:0] sel;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] y1;
  logic [1:0] quad;
  logic sat;
  logic [CNT_W-1:0] sat_cnt;
  logic cnt_clr;
`ifdef QFOLD_OCTANT_EN
  logic oct_swap;
`endif
  modport master (
    output in_valid, x, y, mode, sel, out_ready, cnt_clr,
`ifdef QFOLD_OCTANT_EN
    input oct_swap,
`endif
    input in_ready, out_valid, x1, y1, quad, sat, sat_cnt
  );
  modport slave (
    input in_valid, x, y, mode, sel, out_ready, cnt_clr,
`ifdef QFOLD_OCTANT_EN
    output oct_swap,
`endif
    output in_ready, out_valid, x1, y1, quad, sat, sat_cnt
  );
endinterface

// File: rtl/qfold_neg_sat.sv
// qfold_neg_sat: two's-complement negate that clamps -2^(WIDTH-1) to 2^(WIDTH-1)-1 and flags it
module qfold_neg_sat import qfold_pkg::*; #(
  parameter int WIDTH = QF_WIDTH
) (
  input  logic [WIDTH-1:0] v_i,
  output logic [WIDTH-1:0] n_o,
  output logic             sat_o
);
  assign sat_o = v_i == {1'b1, {(WIDTH-1){1'b0}}};
  assign n_o = sat_o ? {1'b0, {(WIDTH-1){1'b1}}} : ~v_i + 1'b1;
endmodule

// File: rtl/quadrant_fold_pipe.sv
// quadrant_fold_pipe: elastic pipelined quadrant fold with sat counter (QFOLD_OCTANT_EN enables octant swap)
module quadrant_fold_pipe import qfold_pkg::*; #(
  parameter int WIDTH  = QF_WIDTH,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic rst,
  quadrant_fold_pipe_if.slave bus
);
  typedef struct packed {
    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] y1;
    qfold_tag_t tag;
  } pld_t;
  logic xs, ys, swp, na, nb, sa, sb;
  logic [WIDTH-1:0] a, b, an, bn, fx, fy;
  pld_t f;
  pld_t [STAGES-1:0] p_q, p_d;
  logic [STAGES-1:0] v_q, v_d, ld;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign xs = bus.x[WIDTH-1];
  assign ys = bus.y[WIDTH-1];
  assign swp = bus.mode ? bus.sel[0] : xs ^ ys;
  assign na = bus.mode ? bus.sel[1] : ys;
  assign nb = bus.mode ? bus.sel[2] : xs;
  assign a = swp ? bus.y : bus.x;
  assign b = swp ? bus.x : bus.y;
  qfold_neg_sat #(.WIDTH(WIDTH)) u_neg_a (.v_i(a), .n_o(an), .sat_o(sa));
  qfold_neg_sat #(.WIDTH(WIDTH)) u_neg_b (.v_i(b), .n_o(bn), .sat_o(sb));
  assign fx = na ? an : a;
  assign fy = nb ? bn : b;
  // Assemble the stage-1 payload from the shared swap/negate datapath
  always_comb begin
    f = '0;
`ifdef QFOLD_OCTANT_EN
    f.tag.oct_swap = !bus.mode && (fy > fx);
    f.x1 = f.tag.oct_swap ? fy : fx;
    f.y1 = f.tag.oct_swap ? fx : fy;
`else
    f.x1 = fx;
    f.y1 = fy;
`endif
    f.tag.quad = bus.mode ? Q0 : ys ? (xs ? Q2 : Q3) : (xs ? Q1 : Q0);
    f.tag.sat = (na & sa) | (nb & sb);
  end
  genvar i;
  for (i = 0; i < STAGES; i++) begin : g_ld
    assign ld[i] = bus.out_ready || !(&v_q[STAGES-1:i]);
  end
  // Each loading stage takes its upstream neighbour, stage 0 takes the fold result
  always_comb begin
    v_d = v_q;
    p_d = p_q;
    for (int k = 0; k < STAGES; k++) begin
      if (ld[k]) begin
        v_d[k] = k == 0 ? bus.in_valid : v_q[k == 0 ? 0 : k - 1];
        p_d[k] = k == 0 ? f : p_q[k == 0 ? 0 : k - 1];
      end
    end
  end
  // Stage valid and payload registers
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      p_q <= '0;
    end else begin
      v_q <= v_d;
      p_q <= p_d;
    end
  end
  assign cnt_d = bus.cnt_clr ? '0 :
                 (v_q[STAGES-1] && bus.out_ready && p_q[STAGES-1].tag.sat && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  // Saturating count of emitted saturated samples
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign bus.in_ready = ld[0];
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.x1 = p_q[STAGES-1].x1;
  assign bus.y1 = p_q[STAGES-1].y1;
  assign bus.quad = p_q[STAGES-1].tag.quad;
  assign bus.sat = p_q[STAGES-1].tag.sat;
  assign bus.sat_cnt = cnt_q;
`ifdef QFOLD_OCTANT_EN
  assign bus.oct_swap = p_q[STAGES-1].tag.oct_swap;
`endif
endmodule

// File: tb/tb_quadrant_fold_pipe.sv
// tb_quadrant_fold_pipe: randomized and directed checks of quadrant_fold_pipe against a behavioural model
module tb_quadrant_fold_pipe;
  localparam int W = 16;
  localparam int ST = 2;
  localparam int CW = 3;
  typedef struct {
    logic signed [W-1:0] x1;
    logic signed [W-1:0] y1;
    logic [1:0] q;
    logic s;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  quadrant_fold_pipe_if #(.WIDTH(W), .CNT_W(CW)) bus ();
  quadrant_fold_pipe #(.WIDTH(W), .STAGES(ST), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
  int vec = 0;
  int err = 0;
  exp_t exp_q[$];
  logic signed [W-1:0] ox, oy;
  logic [1:0] oq;
  logic os, ov;

  function automatic int neg(input int v, inout bit s);
    if (v == -(1 << (W - 1))) begin
      s = 1'b1;
      return (1 << (W - 1)) - 1;
    end
    return -v;
  endfunction

  function automatic exp_t model(input int x, input int y, input bit md, input bit [2:0] sl);
    exp_t e;
    int rx, ry, q;
    bit s;
    logic [W-1:0] ux, uy;
    s = 1'b0;
    q = 0;
    if (md) begin
      rx = sl[0] ? y : x;
      ry = sl[0] ? x : y;
      if (sl[1]) rx = neg(rx, s);
      if (sl[2]) ry = neg(ry, s);
    end else if (x >= 0 && y >= 0) begin
      rx = x; ry = y;
    end else if (y >= 0) begin
      q = 1; rx = y; ry = neg(x, s);
    end else if (x < 0) begin
      q = 2; rx = neg(x, s); ry = neg(y, s);
    end else begin
      q = 3; rx = neg(y, s); ry = x;
    end
    ux = W'(rx);
    uy = W'(ry);
`ifdef QFOLD_OCTANT_EN
    if (!md && uy > ux) begin
      ux = W'(ry);
      uy = W'(rx);
    end
`endif
    e.x1 = ux;
    e.y1 = uy;
    e.q = 2'(q);
    e.s = s;
    return e;
  endfunction

  task automatic tick(input bit iv, input int xx, input int yy, input bit md, input bit [2:0] sl,
                      input bit ordy, input bit clr, output bit acc, output bit emit);
    @(negedge clk);
    bus.in_valid = iv;
    bus.x = W'(xx);
    bus.y = W'(yy);
    bus.mode = md;
    bus.sel = sl;
    bus.out_ready = ordy;
    bus.cnt_clr = clr;
    #4;
    acc = iv && bus.in_ready;
    ov = bus.out_valid;
    emit = bus.out_valid && ordy;
    ox = bus.x1;
    oy = bus.y1;
    oq = bus.quad;
    os = bus.sat;
    if (acc) exp_q.push_back(model(xx, yy, md, sl));
    @(posedge clk);
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.x = '0; bus.y = '0; bus.mode = 1'b0;
    bus.sel = 3'b000; bus.out_ready = 1'b1; bus.cnt_clr = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    vec++; if (bus.out_valid !== 1'b0) begin err++; $display("FAIL reset out_valid: got %0b want 0", bus.out_valid); end
    vec++; if (bus.in_ready !== 1'b1) begin err++; $display("FAIL reset in_ready: got %0b want 1", bus.in_ready); end
    vec++; if (bus.x1 !== '0 || bus.y1 !== '0) begin err++; $display("FAIL reset x1/y1: got %0h/%0h want 0/0", bus.x1, bus.y1); end
    vec++; if (bus.quad !== 2'd0 || bus.sat !== 1'b0) begin err++; $display("FAIL reset quad/sat: got %0d/%0b want 0/0", bus.quad, bus.sat); end
    vec++; if (bus.sat_cnt !== '0) begin err++; $display("FAIL reset sat_cnt: got %0d want 0", bus.sat_cnt); end
  endtask

  task automatic test_auto();
    int xi[4] = '{3, -3, -7, 0};
    int yi[4] = '{5, 5, -2, -4};
    int ex[4] = '{3, 5, 7, 4};
    int ey[4] = '{5, 3, 2, 0};
    int eq[4] = '{0, 1, 2, 3};
    int sent, got, lat;
    bit a, e;
    sent = 0; got = 0; lat = -1;
    for (int t = 0; t < 40 && got < 4; t++) begin
      tick(sent < 4, sent < 4 ? xi[sent] : 0, sent < 4 ? yi[sent] : 0, 1'b0, 3'b000, 1'b1, 1'b0, a, e);
      if (a) sent++;
      if (e) begin
        void'(exp_q.pop_front());
        if (got == 0) lat = t;
        vec++;
        if (ox !== ex[got] || oy !== ey[got] || oq !== eq[got][1:0] || os !== 1'b0) begin
          err++;
          $display("FAIL auto #%0d: got (%0d,%0d) q%0d s%0b want (%0d,%0d) q%0d s0", got, ox, oy, oq, os, ex[got], ey[got], eq[got]);
        end
        got++;
      end
    end
    vec++; if (lat !== ST) begin err++; $display("FAIL auto latency: got %0d want %0d", lat, ST); end
    vec++; if (got !== 4) begin err++; $display("FAIL auto count: got %0d want 4", got); end
  endtask

  task automatic test_legacy();
    bit [2:0] sl[5] = '{3'b011, 3'b100, 3'b001, 3'b010, 3'b000};
    int xi[5] = '{10, 10, 10, -32768, -5};
    int yi[5] = '{20, 20, 20, 1, -6};
    int ex[5] = '{-20, 10, 20, 32767, -5};
    int ey[5] = '{10, -20, 10, 1, -6};
    bit es[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int sent, got;
    bit a, e;
    sent = 0; got = 0;
    for (int t = 0; t < 40 && got < 5; t++) begin
      tick(sent < 5, sent < 5 ? xi[sent] : 0, sent < 5 ? yi[sent] : 0, 1'b1, sent < 5 ? sl[sent] : 3'b000, 1'b1, 1'b0, a, e);
      if (a) sent++;
      if (e) begin
        void'(exp_q.pop_front());
        vec++;
        if (ox !== ex[got] || oy !== ey[got] || oq !== 2'd0 || os !== es[got]) begin
          err++;
          $display("FAIL legacy #%0d: got (%0d,%0d) q%0d s%0b want (%0d,%0d) q0 s%0b", got, ox, oy, oq, os, ex[got], ey[got], es[got]);
        end
        got++;
      end
    end
    vec++; if (got !== 5) begin err++; $display("FAIL legacy count: got %0d want 5", got); end
  endtask

  task automatic test_sat_cnt();
    int n[3] = '{1, 1, 9};
    int ec[3] = '{1, 0, 7};
    int sent, got;
    bit a, e;
    tick(1'b0, 0, 0, 1'b0, 3'b000, 1'b1, 1'b1, a, e);
    for (int p = 0; p < 3; p++) begin
      sent = 0; got = 0;
      for (int t = 0; t < 60 && got < n[p]; t++) begin
        tick(sent < n[p], -32768, 0, 1'b0, 3'b000, 1'b1, p == 1, a, e);
        if (a) sent++;
        if (e) begin
          void'(exp_q.pop_front());
          got++;
          vec++;
          if (ox !== 16'sd0 || oy !== 16'sd32767 || oq !== 2'd1 || os !== 1'b1) begin
            err++;
            $display("FAIL sat sample: got (%0d,%0d) q%0d s%0b want (0,32767) q1 s1", ox, oy, oq, os);
          end
        end
      end
      #1;
      vec++;
      if (bus.sat_cnt !== CW'(ec[p]) || got !== n[p]) begin
        err++;
        $display("FAIL sat_cnt phase %0d: got cnt %0d after %0d outputs want cnt %0d after %0d", p, bus.sat_cnt, got, ec[p], n[p]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int xi[6], yi[6];
    int sent, got, early, fe, le;
    bit a, e;
    exp_t d;
    for (int k = 0; k < 6; k++) begin
      xi[k] = $signed(16'($urandom));
      yi[k] = $signed(16'($urandom));
    end
    sent = 0; got = 0; early = 0; fe = -1; le = -1;
    for (int t = 0; t < 60 && got < 6; t++) begin
      tick(sent < 6, sent < 6 ? xi[sent] : 0, sent < 6 ? yi[sent] : 0, 1'b0, 3'b000, t >= 5, 1'b0, a, e);
      if (a) sent++;
      if (a && t < 5) early++;
      if (t == 4) begin
        vec++; if (a !== 1'b0) begin err++; $display("FAIL b2b in_ready while full: got 1 want 0"); end
      end
      if (t >= 2 && t < 5) begin
        vec++;
        if (ov !== 1'b1 || ox !== exp_q[0].x1 || oy !== exp_q[0].y1) begin
          err++;
          $display("FAIL b2b hold t%0d: got v%0b (%0d,%0d) want v1 (%0d,%0d)", t, ov, ox, oy, exp_q[0].x1, exp_q[0].y1);
        end
      end
      if (e) begin
        d = exp_q.pop_front();
        if (fe < 0) fe = t;
        le = t;
        got++;
        vec++;
        if (ox !== d.x1 || oy !== d.y1 || oq !== d.q || os !== d.s) begin
          err++;
          $display("FAIL b2b out #%0d: got (%0d,%0d) q%0d s%0b want (%0d,%0d) q%0d s%0b", got, ox, oy, oq, os, d.x1, d.y1, d.q, d.s);
        end
      end
    end
    vec++; if (early !== ST) begin err++; $display("FAIL b2b accepted while stalled: got %0d want %0d", early, ST); end
    vec++; if (got !== 6 || fe !== 5 || le - fe !== 5) begin err++; $display("FAIL b2b drain: got %0d outputs ticks %0d..%0d want 6 outputs ticks 5..10", got, fe, le); end
  endtask

  task automatic test_random();
    int ecnt, xx, yy;
    bit a, e;
    exp_t d;
    tick(1'b0, 0, 0, 1'b0, 3'b000, 1'b1, 1'b1, a, e);
    ecnt = 0;
    for (int t = 0; t < 400; t++) begin
      xx = $urandom_range(0, 5) == 0 ? -32768 : $urandom_range(0, 5) == 0 ? 0 : $signed(16'($urandom));
      yy = $urandom_range(0, 5) == 0 ? -32768 : $urandom_range(0, 5) == 0 ? 0 : $signed(16'($urandom));
      tick(t < 360 && $urandom_range(0, 3) != 0, xx, yy, 1'($urandom), 3'($urandom),
           t >= 360 || $urandom_range(0, 2) != 0, 1'b0, a, e);
      if (e) begin
        vec++;
        if (exp_q.size() == 0) begin
          err++;
          $display("FAIL random spurious output: got (%0d,%0d) want none", ox, oy);
        end else begin
          d = exp_q.pop_front();
          if (d.s && ecnt < 7) ecnt++;
          if (ox !== d.x1 || oy !== d.y1 || oq !== d.q || os !== d.s) begin
            err++;
            $display("FAIL random t%0d: got (%0d,%0d) q%0d s%0b want (%0d,%0d) q%0d s%0b", t, ox, oy, oq, os, d.x1, d.y1, d.q, d.s);
          end
        end
      end
    end
    #1;
    vec++; if (exp_q.size() != 0) begin err++; $display("FAIL random undelivered: got %0d left want 0", exp_q.size()); end
    vec++; if (bus.sat_cnt !== CW'(ecnt)) begin err++; $display("FAIL random sat_cnt: got %0d want %0d", bus.sat_cnt, ecnt); end
  endtask

  task automatic test_reset_mid();
    bit a, e;
    exp_t d;
    int got;
    tick(1'b1, -32768, -32768, 1'b0, 3'b000, 1'b0, 1'b0, a, e);
    tick(1'b1, -32768, -32768, 1'b0, 3'b000, 1'b0, 1'b0, a, e);
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    vec++; if (bus.out_valid !== 1'b0) begin err++; $display("FAIL midreset out_valid: got %0b want 0", bus.out_valid); end
    vec++; if (bus.sat_cnt !== '0) begin err++; $display("FAIL midreset sat_cnt: got %0d want 0", bus.sat_cnt); end
    vec++; if (bus.in_ready !== 1'b1) begin err++; $display("FAIL midreset in_ready: got %0b want 1", bus.in_ready); end
    for (int t = 0; t < 5; t++) begin
      tick(1'b0, 0, 0, 1'b0, 3'b000, 1'b1, 1'b0, a, e);
      vec++; if (ov !== 1'b0) begin err++; $display("FAIL midreset stale output t%0d: got valid 1 want 0", t); end
    end
    got = 0;
    for (int t = 0; t < 10 && got == 0; t++) begin
      tick(t == 0, 3, -9, 1'b0, 3'b000, 1'b1, 1'b0, a, e);
      if (e) begin
        got++;
        d = exp_q.pop_front();
        vec++;
        if (ox !== d.x1 || oy !== d.y1 || oq !== d.q) begin
          err++;
          $display("FAIL midreset recovery: got (%0d,%0d) q%0d want (%0d,%0d) q%0d", ox, oy, oq, d.x1, d.y1, d.q);
        end
      end
    end
    vec++; if (got !== 1) begin err++; $display("FAIL midreset recovery count: got %0d want 1", got); end
  endtask

  initial begin
    test_reset();
    test_auto();
    test_legacy();
    test_sat_cnt();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
